// File: rtl/uart_rx_if.sv
// Serial receive side of a UART link: line input plus received-byte outputs.
interface uart_rx_if;
    logic       rxd;
    logic [7:0] data;
    logic       done;
    logic       frame_err;
    logic       busy;

    // Receiver side: takes the line, reports bytes and status.
    modport slave (
        input  rxd,
        output data,
        output done,
        output frame_err,
        output busy
    );

    // Line driver / byte consumer side.
    modport master (
        output rxd,
        input  data,
        input  done,
        input  frame_err,
        input  busy
    );
endinterface

// File: rtl/uart_rx.sv
// UART 8N1 receiver. Synchronises rxd, times each bit from the start edge with
// a free-wrapping baud counter, majority-votes three mid-bit samples, and
// reports each byte with a one-cycle done strobe or a one-cycle frame_err.
module uart_rx #(
    parameter int unsigned p_sys_clk = 50_000_000,
    parameter int unsigned p_baud    = 115200
) (
    input  logic      clk,
    input  logic      rst,
    uart_rx_if.slave  bus
);
    localparam int unsigned l_baud_max_i = p_sys_clk / p_baud - 1;
    localparam logic [19:0] l_baud_max   = 20'(l_baud_max_i);
    localparam logic [19:0] l_half       = 20'(l_baud_max_i / 2);
    localparam logic [19:0] l_half_m1    = l_half - 20'd1;
    localparam logic [19:0] l_half_p1    = l_half + 20'd1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP,
        S_WAIT_HI
    } state_t;

    state_t      state;
    state_t      state_next;
    logic        sync1;
    logic        rxd_s;
    logic [19:0] baud_cnt;
    logic [2:0]  bit_cnt;
    logic [7:0]  shift;
    logic        samp_a;
    logic        samp_b;
    logic [7:0]  data_q;
    logic        done_q;
    logic        ferr_q;

    logic        decide;
    logic        bit_val;
    logic        start_det;
    logic        shift_en;
    logic        bit_clr;
    logic        bit_inc;
    logic        load;
    logic        err;

    assign decide  = (baud_cnt == l_half_p1);
    assign bit_val = (samp_a & samp_b) | (samp_a & rxd_s) | (samp_b & rxd_s);

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state <= S_IDLE;
        else     state <= state_next;
    end

    // Next-state decode and per-cycle control strobes.
    always_comb begin
        state_next = state;
        start_det  = 1'b0;
        shift_en   = 1'b0;
        bit_clr    = 1'b0;
        bit_inc    = 1'b0;
        load       = 1'b0;
        err        = 1'b0;
        case (state)
            S_IDLE: begin
                if (!rxd_s) begin
                    state_next = S_START;
                    start_det  = 1'b1;
                end
            end
            S_START: begin
                if (decide) begin
                    if (!bit_val) begin
                        state_next = S_DATA;
                        bit_clr    = 1'b1;
                    end else begin
                        state_next = S_IDLE;
                    end
                end
            end
            S_DATA: begin
                if (decide) begin
                    shift_en = 1'b1;
                    if (bit_cnt == 3'd7) state_next = S_STOP;
                    else                 bit_inc    = 1'b1;
                end
            end
            S_STOP: begin
                if (decide) begin
                    if (bit_val) begin
                        load       = 1'b1;
                        state_next = S_IDLE;
                    end else begin
                        err        = 1'b1;
                        state_next = S_WAIT_HI;
                    end
                end
            end
            S_WAIT_HI: begin
                if (rxd_s) state_next = S_IDLE;
            end
            default: state_next = S_IDLE;
        endcase
    end

    // Two-flop synchroniser for the asynchronous line; resets to idle-high.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1 <= 1'b1;
            rxd_s <= 1'b1;
        end else begin
            sync1 <= bus.rxd;
            rxd_s <= sync1;
        end
    end

    // Bit timing: zeroed on start edge, then wraps freely for the whole frame;
    // captures the first two of the three vote samples.
    always_ff @(posedge clk) begin
        if (rst) begin
            baud_cnt <= '0;
            samp_a   <= 1'b1;
            samp_b   <= 1'b1;
        end else begin
            if (start_det)
                baud_cnt <= '0;
            else if (state != S_IDLE)
                baud_cnt <= (baud_cnt == l_baud_max) ? '0 : baud_cnt + 20'd1;
            if (baud_cnt == l_half_m1) samp_a <= rxd_s;
            if (baud_cnt == l_half)    samp_b <= rxd_s;
        end
    end

    // Bit counter, LSB-first shift register and registered result strobes.
    always_ff @(posedge clk) begin
        if (rst) begin
            bit_cnt <= '0;
            shift   <= '0;
            data_q  <= '0;
            done_q  <= 1'b0;
            ferr_q  <= 1'b0;
        end else begin
            if (bit_clr)       bit_cnt <= '0;
            else if (bit_inc)  bit_cnt <= bit_cnt + 3'd1;
            if (shift_en)      shift   <= {bit_val, shift[7:1]};
            if (load)          data_q  <= shift;
            done_q <= load;
            ferr_q <= err;
        end
    end

    assign bus.data      = data_q;
    assign bus.done      = done_q;
    assign bus.frame_err = ferr_q;
    assign bus.busy      = (state != S_IDLE);
endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx at 10 clocks per bit.
module tb_uart_rx;
    localparam int BIT_CLK = 10;

    typedef struct {
        logic [7:0] val;
        logic       stop_v;
        int         spike_bit;
        int         idle_after;
        logic       exp_done;
        logic       exp_ferr;
    } vec_t;

    logic clk;
    logic rst;
    uart_rx_if bus();

    uart_rx #(.p_sys_clk(1_000_000), .p_baud(100_000)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int         checks = 0;
    int         errors = 0;
    int         done_cnt = 0;
    int         ferr_cnt = 0;
    logic [7:0] sb[$];
    logic [7:0] last_good;
    logic       prev_done = 1'b0;
    logic       prev_ferr = 1'b0;
    logic [7:0] prev_data;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic hold(input logic v, input int n);
        bus.rxd = v;
        repeat (n) @(negedge clk);
    endtask

    // Serialiser acting as the transmitter: start, 8 data bits LSB first, stop.
    task automatic send_frame(input logic [7:0] v, input logic stop, input int spike_bit,
                              input bit push);
        if (push) sb.push_back(v);
        hold(1'b0, BIT_CLK);
        for (int i = 0; i < 8; i++) begin
            if (i == spike_bit) begin
                hold(v[i], 5);
                hold(~v[i], 1);
                hold(v[i], 4);
            end else begin
                hold(v[i], BIT_CLK);
            end
        end
        hold(stop, BIT_CLK);
    endtask

    // Output monitor: scoreboard pops on done, pulse width/exclusivity checks.
    always @(negedge clk) begin
        logic [7:0] exp_v;
        if (!rst) begin
            if (bus.done) begin
                done_cnt++;
                if (sb.size() == 0) begin
                    chk("sb_unexpected_done", 32'd1, 32'd0);
                end else begin
                    exp_v = sb.pop_front();
                    chk("sb_data", {24'd0, bus.data}, {24'd0, exp_v});
                end
                chk("done_width", {31'd0, prev_done}, 32'd0);
            end
            if (bus.frame_err) begin
                ferr_cnt++;
                chk("ferr_width", {31'd0, prev_ferr}, 32'd0);
            end
            if (bus.done || bus.frame_err)
                chk("done_ferr_excl", {31'd0, bus.done & bus.frame_err}, 32'd0);
            if (bus.data != prev_data)
                chk("data_change_with_done", {31'd0, bus.done}, 32'd1);
        end
        prev_done = bus.done;
        prev_ferr = bus.frame_err;
        prev_data = bus.data;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog time limit reached");
        $fatal(1);
    end

    initial begin
        vec_t vecs[8];
        int   d0;
        int   f0;
        logic [7:0] v;

        vecs[0] = '{8'hA5, 1'b1, -1, 10, 1'b1, 1'b0};
        vecs[1] = '{8'h00, 1'b1, -1,  0, 1'b1, 1'b0};
        vecs[2] = '{8'hFF, 1'b1, -1, 10, 1'b1, 1'b0};
        vecs[3] = '{8'hC3, 1'b1,  3, 10, 1'b1, 1'b0};
        vecs[4] = '{8'h01, 1'b1, -1,  5, 1'b1, 1'b0};
        vecs[5] = '{8'h80, 1'b1, -1, 10, 1'b1, 1'b0};
        vecs[6] = '{8'h5A, 1'b0, -1, 20, 1'b0, 1'b1};
        vecs[7] = '{8'h7E, 1'b1, -1, 10, 1'b1, 1'b0};

        rst     = 1'b1;
        bus.rxd = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("reset_data", {24'd0, bus.data}, 32'd0);
        chk("reset_done", {31'd0, bus.done}, 32'd0);
        chk("reset_ferr", {31'd0, bus.frame_err}, 32'd0);
        chk("reset_busy", {31'd0, bus.busy}, 32'd0);
        last_good = 8'h00;
        hold(1'b1, 5);

        // Table-driven frames, including back-to-back and majority-vote spike.
        for (int i = 0; i < 8; i++) begin
            d0 = done_cnt;
            f0 = ferr_cnt;
            send_frame(vecs[i].val, vecs[i].stop_v, vecs[i].spike_bit, vecs[i].exp_done);
            if (vecs[i].idle_after > 0) hold(1'b1, vecs[i].idle_after);
            if (vecs[i].exp_done) last_good = vecs[i].val;
            chk($sformatf("vec%0d_done", i), done_cnt - d0, {31'd0, vecs[i].exp_done});
            chk($sformatf("vec%0d_ferr", i), ferr_cnt - f0, {31'd0, vecs[i].exp_ferr});
            chk($sformatf("vec%0d_data", i), {24'd0, bus.data}, {24'd0, last_good});
        end

        // Short start glitch: START must abort without output.
        d0 = done_cnt;
        f0 = ferr_cnt;
        hold(1'b0, 2);
        hold(1'b1, 2);
        chk("glitch_busy_rise", {31'd0, bus.busy}, 32'd1);
        for (int i = 0; i < 12 && bus.busy; i++) @(negedge clk);
        chk("glitch_busy_fall", {31'd0, bus.busy}, 32'd0);
        hold(1'b1, 10);
        chk("glitch_done", done_cnt - d0, 32'd0);
        chk("glitch_ferr", ferr_cnt - f0, 32'd0);

        // Stop bit low followed by a held-low line.
        d0 = done_cnt;
        f0 = ferr_cnt;
        send_frame(8'h55, 1'b0, -1, 1'b0);
        hold(1'b0, 30);
        chk("break_busy_high", {31'd0, bus.busy}, 32'd1);
        chk("break_ferr", ferr_cnt - f0, 32'd1);
        chk("break_done", done_cnt - d0, 32'd0);
        chk("break_data_kept", {24'd0, bus.data}, {24'd0, last_good});
        bus.rxd = 1'b1;
        for (int i = 0; i < 8 && bus.busy; i++) @(negedge clk);
        chk("break_busy_fall", {31'd0, bus.busy}, 32'd0);
        hold(1'b1, 10);

        // Reset in the middle of bit 4, then a clean frame.
        v = 8'h96;
        hold(1'b0, BIT_CLK);
        for (int i = 0; i < 4; i++) hold(v[i], BIT_CLK);
        hold(v[4], 3);
        rst     = 1'b1;
        bus.rxd = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("midrst_data", {24'd0, bus.data}, 32'd0);
        chk("midrst_busy", {31'd0, bus.busy}, 32'd0);
        chk("midrst_done", {31'd0, bus.done}, 32'd0);
        chk("midrst_ferr", {31'd0, bus.frame_err}, 32'd0);
        hold(1'b1, 5);
        d0 = done_cnt;
        send_frame(8'h3C, 1'b1, -1, 1'b1);
        hold(1'b1, 10);
        last_good = 8'h3C;
        chk("midrst_frame_done", done_cnt - d0, 32'd1);
        chk("midrst_frame_data", {24'd0, bus.data}, 32'h3C);

        // Loopback-style stream of random bytes with no idle between frames.
        d0 = done_cnt;
        for (int i = 0; i < 24; i++) begin
            v = 8'($urandom_range(0, 255));
            send_frame(v, 1'b1, -1, 1'b1);
            last_good = v;
        end
        hold(1'b1, 20);
        chk("loop_done", done_cnt - d0, 32'd24);
        chk("loop_last_data", {24'd0, bus.data}, {24'd0, last_good});
        chk("sb_empty", sb.size(), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
